imem_readback: RTL and testbench
================================

IMEM_READBACK -- requirements
Module: imem_readback

Interface
REQ-001 Parameter ADDR_W, default 12, instruction-memory address width.
REQ-002 Parameter DATA_W, default 32, instruction word width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begins a dump, sampled only in IDLE.
REQ-006 abort  input  1  ends an active dump at the next edge.
REQ-007 start_adrs  input  ADDR_W  first address to read, captured on accepted start.
REQ-008 end_adrs  input  ADDR_W  last address to read, captured on accepted start.
REQ-009 mem_rd_en  output  1  memory read strobe.
REQ-010 mem_rd_adrs  output  ADDR_W  memory read address.
REQ-011 mem_rd_instr  input  DATA_W  read data, valid exactly one cycle after mem_rd_en.
REQ-012 dump_valid  output  1  dump word present.
REQ-013 dump_ready  input  1  consumer accepts the word when high with dump_valid.
REQ-014 dump_data  output  DATA_W  dumped instruction word.
REQ-015 dump_adrs  output  ADDR_W  address of dump_data.
REQ-016 cpu_hold  output  1  high while busy; forces the CPU disabled.
REQ-017 busy  output  1  high in every state except IDLE and DONE.
REQ-018 done  output  1  one-cycle pulse on dump completion or abort.

Function
REQ-019 FSM states SHALL be IDLE, READ, WAIT, SEND and DONE.
REQ-020 IDLE->READ on start; capture start_adrs into a counter and end_adrs into a limit register.
REQ-021 READ: mem_rd_en=1 and mem_rd_adrs=counter for exactly one cycle, then ->WAIT.
REQ-022 WAIT: capture mem_rd_instr into dump_data and counter into dump_adrs, then ->SEND.
REQ-023 SEND: dump_valid=1; dump_data and dump_adrs held stable until dump_valid&&dump_ready.
REQ-024 On handshake: if counter==limit ->DONE, else counter+1 modulo 2^ADDR_W and ->READ.
REQ-025 Minimum latency from start to first dump_valid SHALL be 3 cycles; sustained throughput SHALL be one word per 3 cycles with dump_ready tied high.
REQ-026 If end_adrs<start_adrs, the counter SHALL wrap from 2^ADDR_W-1 to 0 and continue to limit.
REQ-027 If end_adrs==start_adrs, exactly one word SHALL be dumped.
REQ-028 DONE SHALL assert done for one cycle, then ->IDLE.
REQ-029 start while busy SHALL be ignored, with no effect on counter or limit.
REQ-030 abort in READ, WAIT or SEND SHALL ->DONE next edge; abort outranks a same-cycle handshake; the word in SEND is dropped.
REQ-031 dump_valid SHALL never deassert in SEND without a handshake or an abort.
REQ-032 mem_rd_en SHALL be low in all states except READ.

Reset
REQ-033 rst SHALL immediately force state IDLE, independent of clk.
REQ-034 During rst, all outputs (mem_rd_en, mem_rd_adrs, dump_valid, dump_data, dump_adrs, cpu_hold, busy, done) SHALL be 0, including when rst asserts mid-dump.
REQ-035 After rst deasserts, the block SHALL wait in IDLE for a new start.

Configuration
REQ-036 Macro IMEM_READBACK_SKIP_ZERO_EN: when defined, a word equal to 0 captured in WAIT SHALL skip SEND.
REQ-037 With the macro defined, a skipped word SHALL take the REQ-024 branch directly, with no dump_valid; done SHALL still pulse at the limit.
REQ-038 Without the macro, every address in range SHALL be dumped, including zero words.

Verification
REQ-039 Load mem[0]=0x18001000, mem[1]=0x58001000; start, start_adrs=0, end_adrs=1, ready=1 -> two dumps (0,0x18001000),(1,0x58001000), done pulses, first valid 3 cycles after start.
REQ-040 Same range, dump_ready low for 5 cycles on word 0 -> dump_valid and dump_data held stable 5 cycles, then both words delivered in order.
REQ-041 start_adrs=4094, end_adrs=1 -> dump addresses 4094,4095,0,1 and then done.
REQ-042 abort asserted in SEND of word 2 of range 0..15 -> no further dump_valid, done pulses next cycle, busy=0 after DONE.
REQ-043 rst pulsed mid-WAIT -> all outputs 0 immediately; next start dumps from the new start_adrs.
REQ-044 With IMEM_READBACK_SKIP_ZERO_EN, range 0..15 with only mem[0], mem[1], mem[15] nonzero -> exactly 3 dumps and a single done.

Source files
------------

// File: rtl/imem_readback.sv
// imem_readback: walks an address range of instruction memory and presents
// each word on a valid/ready dump port while holding the CPU disabled.
// One word takes three cycles: READ (strobe), WAIT (data returns), SEND.
// Optional build macro IMEM_READBACK_SKIP_ZERO_EN: words reading as zero are
// not presented on the dump port and the walk moves straight on.
`timescale 1ns/1ps
module imem_readback #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_adrs,
  input  logic [ADDR_W-1:0] end_adrs,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_adrs,
  input  logic [DATA_W-1:0] mem_rd_instr,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_adrs,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DONE} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] counter_reg;
  logic [ADDR_W-1:0] limit_reg;
  logic [ADDR_W-1:0] mem_rd_adrs_reg;
  logic [ADDR_W-1:0] dump_adrs_reg;
  logic [DATA_W-1:0] dump_data_reg;
  logic              mem_rd_en_reg;
  logic              dump_valid_reg;
  logic              busy_reg;
  logic              done_reg;

  logic              last_word;
  logic [ADDR_W-1:0] counter_inc;

  // The limit comparison and the wrapping increment feed the advance branch.
  assign last_word   = (counter_reg == limit_reg);
  assign counter_inc = counter_reg + ADDR_W'(1);

  // Every output comes straight from a register updated alongside the state.
  assign mem_rd_en   = mem_rd_en_reg;
  assign mem_rd_adrs = mem_rd_adrs_reg;
  assign dump_valid  = dump_valid_reg;
  assign dump_data   = dump_data_reg;
  assign dump_adrs   = dump_adrs_reg;
  assign busy        = busy_reg;
  assign cpu_hold    = busy_reg;
  assign done        = done_reg;

  // Dump sequencer: state, address walk and registered outputs together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      counter_reg     <= '0;
      limit_reg       <= '0;
      mem_rd_en_reg   <= 1'b0;
      mem_rd_adrs_reg <= '0;
      dump_valid_reg  <= 1'b0;
      dump_data_reg   <= '0;
      dump_adrs_reg   <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      // Strobe and done are single-cycle unless a branch re-arms them.
      mem_rd_en_reg <= 1'b0;
      done_reg      <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            counter_reg     <= start_adrs;
            limit_reg       <= end_adrs;
            mem_rd_adrs_reg <= start_adrs;
            mem_rd_en_reg   <= 1'b1;
            busy_reg        <= 1'b1;
            state_reg       <= READ;
          end
        end
        READ, WAIT, SEND: begin
          if (abort) begin
            // Abort wins over everything, including a same-cycle handshake.
            dump_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b1;
            state_reg      <= DONE;
          end else if (state_reg == READ) begin
            state_reg <= WAIT;
          end else if (state_reg == WAIT) begin
            dump_data_reg <= mem_rd_instr;
            dump_adrs_reg <= counter_reg;
`ifdef IMEM_READBACK_SKIP_ZERO_EN
            if (mem_rd_instr == '0) begin
              if (last_word) begin
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
                state_reg <= DONE;
              end else begin
                counter_reg     <= counter_inc;
                mem_rd_adrs_reg <= counter_inc;
                mem_rd_en_reg   <= 1'b1;
                state_reg       <= READ;
              end
            end else begin
              dump_valid_reg <= 1'b1;
              state_reg      <= SEND;
            end
`else
            dump_valid_reg <= 1'b1;
            state_reg      <= SEND;
`endif
          end else if (dump_ready) begin
            // SEND with handshake: finish at the limit, else fetch next word.
            dump_valid_reg <= 1'b0;
            if (last_word) begin
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              counter_reg     <= counter_inc;
              mem_rd_adrs_reg <= counter_inc;
              mem_rd_en_reg   <= 1'b1;
              state_reg       <= READ;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_readback.sv
// Scoreboard bench for imem_readback: a reference walk of the address range
// pushes expected (address, word) pairs; a monitor pops them on handshakes.
`timescale 1ns/1ps
module tb_imem_readback;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef IMEM_READBACK_SKIP_ZERO_EN
  localparam bit SKIP_ZERO = 1'b1;
`else
  localparam bit SKIP_ZERO = 1'b0;
`endif

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] start_adrs;
  logic [ADDR_W-1:0] end_adrs;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_adrs;
  logic [DATA_W-1:0] mem_rd_instr;
  logic              dump_valid;
  logic              dump_ready;
  logic [DATA_W-1:0] dump_data;
  logic [ADDR_W-1:0] dump_adrs;
  logic              cpu_hold;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] mem [DEPTH];
  exp_t              exp_q[$];
  int                hs_cycles[$];
  int                total = 0;
  int                bad = 0;
  int                done_cnt = 0;
  int                hs_count = 0;
  int                cyc = 0;
  int                ready_mode = 0;  // 0 high, 1 random, 2 low

  imem_readback #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .start_adrs   (start_adrs),
    .end_adrs     (end_adrs),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_adrs  (mem_rd_adrs),
    .mem_rd_instr (mem_rd_instr),
    .dump_valid   (dump_valid),
    .dump_ready   (dump_ready),
    .dump_data    (dump_data),
    .dump_adrs    (dump_adrs),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory with one-cycle read latency; garbage when not strobed.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_instr <= mem[mem_rd_adrs];
    else           mem_rd_instr <= $urandom;
  end

  // Consumer ready pattern.
  initial begin
    dump_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       dump_ready = 1'b1;
        1:       dump_ready = 1'($urandom_range(0, 1));
        default: dump_ready = 1'b0;
      endcase
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a handshake is valid && ready without a same-cycle abort.
  always @(negedge clk) begin
    if (!rst) begin
      if (dump_valid && dump_ready && !abort) begin
        hs_count++;
        hs_cycles.push_back(cyc);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_dump: got adrs=%0h data=%0h expected none", dump_adrs, dump_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("dump adrs=%0h data=%08h (exp %0h/%08h)", dump_adrs, dump_data, e.a, e.d);
          check("dump_adrs", 64'(dump_adrs), 64'(e.a));
          check("dump_data", 64'(dump_data), 64'(e.d));
        end
      end
      if (done) done_cnt++;
    end
  end

  // Reference walk: every address from s up to e, wrapping past the top.
  task automatic push_range(input int s, input int e);
    int a;
    a = s;
    forever begin
      if (!(SKIP_ZERO && mem[a] == 0)) exp_q.push_back('{a: a[ADDR_W-1:0], d: mem[a]});
      if (a == e) break;
      a = (a + 1) % DEPTH;
    end
  endtask

  task automatic clear_stats();
    exp_q.delete();
    hs_cycles.delete();
    done_cnt = 0;
    hs_count = 0;
  endtask

  // Pulse start; returns one tick after the accepting edge.
  task automatic do_start(input int s, input int e);
    start_adrs = s[ADDR_W-1:0];
    end_adrs   = e[ADDR_W-1:0];
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_done_seen"}, 64'(done), 64'(1));
    @(posedge clk);
    #1;
    check({name, "_idle_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int n;
    int exp_n;
    logic [DATA_W-1:0] held_d;
    logic [ADDR_W-1:0] held_a;
    logic found;
    logic seen_valid;

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    start_adrs = '0; end_adrs = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    repeat (3) @(negedge clk);
    check("rst_mem_rd_en", 64'(mem_rd_en), 64'(0));
    check("rst_dump_valid", 64'(dump_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Two-word dump, ready high: latency and throughput.
    mem[0] = 32'h18001000;
    mem[1] = 32'h58001000;
    clear_stats();
    ready_mode = 0;
    push_range(0, 1);
    do_start(0, 1);
    check("t1_rd_en", 64'(mem_rd_en), 64'(1));
    check("t1_rd_adrs", 64'(mem_rd_adrs), 64'(0));
    check("t1_cpu_hold", 64'(cpu_hold), 64'(1));
    n = 1;
    while (!dump_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t1_latency", 64'(n), 64'(3));
    wait_done("t1");
    check("t1_queue_empty", 64'(exp_q.size()), 64'(0));
    check("t1_done_count", 64'(done_cnt), 64'(1));
    if (hs_cycles.size() >= 2) check("t1_throughput", 64'(hs_cycles[1] - hs_cycles[0]), 64'(3));
    else check("t1_hs_count", 64'(hs_cycles.size()), 64'(2));

    // Stall on word 0 for 5 cycles; a start while busy must be ignored.
    clear_stats();
    ready_mode = 2;
    push_range(0, 1);
    do_start(0, 1);
    n = 0;
    while (!dump_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    held_d = dump_data;
    held_a = dump_adrs;
    check("t2_first_data", 64'(held_d), 64'(32'h18001000));
    start_adrs = 12'd50; end_adrs = 12'd60; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      check("t2_hold_valid", 64'(dump_valid), 64'(1));
      check("t2_hold_data", 64'(dump_data), 64'(held_d));
      check("t2_hold_adrs", 64'(dump_adrs), 64'(held_a));
    end
    ready_mode = 0;
    wait_done("t2");
    check("t2_queue_empty", 64'(exp_q.size()), 64'(0));
    check("t2_done_count", 64'(done_cnt), 64'(1));

    // Wrap from the top of memory back to zero.
    clear_stats();
    push_range(4094, 1);
    do_start(4094, 1);
    wait_done("t3");
    check("t3_queue_empty", 64'(exp_q.size()), 64'(0));
    check("t3_done_count", 64'(done_cnt), 64'(1));

    // Abort while word 2 of 0..15 is on the port, with ready high.
    clear_stats();
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000 + i;
    push_range(0, 1);
    do_start(0, 15);
    n = 0;
    found = 1'b0;
    while (!found && n < 100) begin
      if (dump_valid && dump_adrs == 12'd2) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    check("t4_reached_word2", 64'(found), 64'(1));
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("t4_done_pulse", 64'(done), 64'(1));
    check("t4_busy", 64'(busy), 64'(0));
    check("t4_valid_dropped", 64'(dump_valid), 64'(0));
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (dump_valid || busy) seen_valid = 1'b1;
    end
    check("t4_quiet_after_abort", 64'(seen_valid), 64'(0));
    check("t4_done_count", 64'(done_cnt), 64'(1));
    check("t4_queue_empty", 64'(exp_q.size()), 64'(0));

    // Reset during WAIT, then dump from a new start address.
    clear_stats();
    do_start(7, 12);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t5_mem_rd_en", 64'(mem_rd_en), 64'(0));
    check("t5_mem_rd_adrs", 64'(mem_rd_adrs), 64'(0));
    check("t5_dump_valid", 64'(dump_valid), 64'(0));
    check("t5_dump_data", 64'(dump_data), 64'(0));
    check("t5_dump_adrs", 64'(dump_adrs), 64'(0));
    check("t5_cpu_hold", 64'(cpu_hold), 64'(0));
    check("t5_busy", 64'(busy), 64'(0));
    check("t5_done", 64'(done), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("t5_idle_after_rst", 64'(busy), 64'(0));
    clear_stats();
    push_range(100, 102);
    do_start(100, 102);
    check("t5_new_rd_adrs", 64'(mem_rd_adrs), 64'(100));
    wait_done("t5");
    check("t5_queue_empty", 64'(exp_q.size()), 64'(0));

    // Sparse range: only mem[0], mem[1], mem[15] nonzero.
    clear_stats();
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = 32'h18001000; mem[1] = 32'h58001000; mem[15] = 32'hdeadbeef;
    push_range(0, 15);
    exp_n = exp_q.size();
    do_start(0, 15);
    wait_done("t6");
    check("t6_dump_count", 64'(hs_count), 64'(exp_n));
    check("t6_done_count", 64'(done_cnt), 64'(1));
    check("t6_queue_empty", 64'(exp_q.size()), 64'(0));

    // Randomized ranges, memory contents and consumer back-pressure.
    ready_mode = 1;
    for (int it = 0; it < 30; it++) begin
      int s;
      int e;
      s = (it == 0) ? 4093 : int'($urandom_range(0, DEPTH - 1));
      e = (s + int'($urandom_range(0, 6))) % DEPTH;
      for (int k = 0; k < 8; k++)
        mem[(s + k) % DEPTH] = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
      clear_stats();
      push_range(s, e);
      do_start(s, e);
      wait_done("rnd");
      check("rnd_queue_empty", 64'(exp_q.size()), 64'(0));
      check("rnd_done_count", 64'(done_cnt), 64'(1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
